// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single shared synchronous memory port.
// Alternating priority, with a bounded DMA burst before a waiting CPU is served.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA} owner_t;

  owner_t             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               cpu_rvalid_q, cpu_rvalid_d;
  logic               dma_rvalid_q, dma_rvalid_d;
  logic               win_cpu, win_dma;

  always_comb begin
    win_cpu = 1'b0;
    win_dma = 1'b0;
    case (state_q)
      S_CPU: begin
        if (dma_req)      win_dma = 1'b1;
        else if (cpu_req) win_cpu = 1'b1;
      end
      S_DMA: begin
        // A waiting CPU preempts only once the DMA burst budget is exhausted
        if (cpu_req && (burst_cnt_q == CNT_W'(MAX_BURST))) win_cpu = 1'b1;
        else if (dma_req)                                  win_dma = 1'b1;
        else if (cpu_req)                                  win_cpu = 1'b1;
      end
      default: begin
        if (cpu_req)      win_cpu = 1'b1;
        else if (dma_req) win_dma = 1'b1;
      end
    endcase
  end

  assign cpu_gnt = win_cpu & ~reset;
  assign dma_gnt = win_dma & ~reset;

  always_comb begin
    state_d      = S_IDLE;
    burst_cnt_d  = '0;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    if (cpu_gnt) begin
      state_d      = S_CPU;
      mem_addr_d   = cpu_addr;
      mem_we_d     = cpu_we;
      mem_wdata_d  = cpu_wdata;
      cpu_rvalid_d = ~cpu_we;
    end else if (dma_gnt) begin
      state_d      = S_DMA;
      burst_cnt_d  = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q
                                                        : burst_cnt_q + CNT_W'(1);
      mem_addr_d   = dma_addr;
      mem_we_d     = dma_we;
      mem_wdata_d  = dma_wdata;
      dma_rvalid_d = ~dma_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      burst_cnt_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: grant pattern checked per row, registered
// memory-side results checked one cycle later through an expectation queue.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
  logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic cr, cw; logic [15:0] ca; logic [7:0] cd;
    logic dr, dw; logic [15:0] da; logic [7:0] dd;
    logic ec, ed;
  } row_t;

  typedef struct {
    logic [15:0] addr; logic we; logic [7:0] wdata; logic crv, drv;
  } exp_t;

  row_t        rows[$];
  exp_t        sb[$];
  int unsigned n_checks = 0, n_errors = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic cr, cw, input logic [15:0] ca, input logic [7:0] cd,
                     input logic dr, dw, input logic [15:0] da, input logic [7:0] dd,
                     input logic ec, ed);
    row_t r;
    r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
    r.ec = ec; r.ed = ed;
    rows.push_back(r);
  endtask

  task automatic run_row(input row_t r);
    exp_t e;
    @(negedge clk);
    cpu_req = r.cr; cpu_we = r.cw; cpu_addr = r.ca; cpu_wdata = r.cd;
    dma_req = r.dr; dma_we = r.dw; dma_addr = r.da; dma_wdata = r.dd;
    mem_rdata = 8'($urandom_range(0, 255));
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.crv));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(e.drv));
      if (e.crv) chk("cpu_rdata", 32'(cpu_rdata), 32'(mem_rdata));
      if (e.drv) chk("dma_rdata", 32'(dma_rdata), 32'(mem_rdata));
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'(r.ec));
    chk("dma_gnt", 32'(dma_gnt), 32'(r.ed));
    e.we = 1'b0; e.crv = 1'b0; e.drv = 1'b0;
    if (r.ec) begin
      m_addr = r.ca; m_wdata = r.cd; e.we = r.cw; e.crv = ~r.cw;
    end else if (r.ed) begin
      m_addr = r.da; m_wdata = r.dd; e.we = r.dw; e.drv = ~r.dw;
    end
    e.addr = m_addr; e.wdata = m_wdata;
    sb.push_back(e);
  endtask

  row_t none_r, both_r;

  initial begin
    // Expected grant pattern derived by hand for MAX_BURST = 4
    add(1, 0, 16'hFFFC, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 0);
    add(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++)
      add(1, 0, 16'h1000 + 16'(i), 8'h10 + 8'(i), 1, 0, 16'h2000 + 16'(i), 8'h20 + 8'(i),
          (i == 0 || i == 5), !(i == 0 || i == 5));
    add(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0200, 8'hA5, 0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 0, 16'h0000, 8'h00, 1, 0, 16'h3000 + 16'(i), 8'h30 + 8'(i), 0, 1);
    add(1, 0, 16'h4000, 8'h40, 1, 0, 16'h3100, 8'h31, 1, 0);
    add(1, 1, 16'h4001, 8'h77, 0, 0, 16'h0000, 8'h00, 1, 0);
    add(1, 0, 16'h4002, 8'h42, 0, 0, 16'h0000, 8'h00, 1, 0);
    add(0, 0, 16'h0000, 8'h00, 1, 1, 16'h3200, 8'h3C, 0, 1);
    add(1, 0, 16'h4003, 8'h43, 1, 0, 16'h3201, 8'h32, 0, 1);
    add(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);

    none_r = rows[1];
    both_r = rows[2];
    both_r.ca = 16'h5005; both_r.da = 16'h6006;

    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hABCD; cpu_wdata = 8'h11;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h1234; dma_wdata = 8'h22;
    mem_rdata = 8'h00;
    #2;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;

    foreach (rows[i]) run_row(rows[i]);

    // Reset asserted mid-cycle while a CPU read result is being returned
    both_r.dr = 1'b0; both_r.ed = 1'b0; both_r.ec = 1'b1; both_r.ca = 16'h1234;
    run_row(both_r);
    sb.delete();
    @(posedge clk);
    #2;
    chk("pre_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("pre_rst_mem_addr", 32'(mem_addr), 32'h1234);
    #1 reset = 1'b1;
    #1;
    chk("async_mem_we", 32'(mem_we), 32'd0);
    chk("async_mem_addr", 32'(mem_addr), 32'd0);
    chk("async_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("async_cpu_gnt", 32'(cpu_gnt), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0;
    #1;
    chk("late_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("late_mem_addr", 32'(mem_addr), 32'd0);
    m_addr = '0; m_wdata = '0;

    // First edge after release must arbitrate from IDLE: CPU wins a tie
    both_r = rows[2];
    both_r.ca = 16'h5005; both_r.da = 16'h6006;
    run_row(both_r);
    run_row(none_r);
    run_row(none_r);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
